// File: rtl/button_sync.sv
// Push-button conditioner: synchronizes a raw button level, optionally debounces it,
// and emits a single-cycle pulse for each accepted press.
module button_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic bi,
    output logic bo
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f;
    logic [1:0]             state_q;
    logic [1:0]             state_d;

    // bi goes straight into the first flop; nothing combinational in front of it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bi};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign f = s;
        end else begin : g_debounce
            localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

            logic [CntW-1:0] cnt_q;
            logic [CntW-1:0] cnt_d;
            logic            f_q;
            logic            f_d;

            // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks.
            always_comb begin
                cnt_d = cnt_q;
                f_d   = f_q;
                if (s == f_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    f_d   = s;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    cnt_q <= '0;
                    f_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    f_q   <= f_d;
                end
            end

            assign f = f_q;
        end
    endgenerate

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = f ? S_PULSE : S_IDLE;
            S_PULSE: state_d = f ? S_HOLD : S_IDLE;
            S_HOLD:  state_d = f ? S_HOLD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output straight from the state register keeps bo glitch-free.
    assign bo = (state_q == S_PULSE);

endmodule

// File: tb/tb_button_sync.sv
// Directed bench for button_sync: a bypass instance and a DEBOUNCE_CYCLES=4 instance
// share clock and reset; pulses are counted by a monitor sampled after each falling edge.
module tb_button_sync;

    logic Clk = 1'b0;
    logic Rst;
    logic bi0;
    logic bi1;
    logic bo0;
    logic bo1;

    int total = 0;
    int bad   = 0;

    int rise0 = 0;
    int hi0   = 0;
    int rise1 = 0;
    int hi1   = 0;
    logic p0  = 1'b0;
    logic p1  = 1'b0;

    int r_snap;
    int h_snap;

    always #10 Clk = ~Clk;

    button_sync #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(0)
    ) u_dut0 (
        .Clk(Clk),
        .Rst(Rst),
        .bi (bi0),
        .bo (bo0)
    );

    button_sync #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) u_dut1 (
        .Clk(Clk),
        .Rst(Rst),
        .bi (bi1),
        .bo (bo1)
    );

    // Counts high cycles and rising edges of bo; equal counts mean every pulse was 1 wide.
    always begin
        @(negedge Clk);
        #2;
        if (bo0 === 1'b1) hi0++;
        if (bo0 === 1'b1 && p0 !== 1'b1) rise0++;
        p0 = bo0;
        if (bo1 === 1'b1) hi1++;
        if (bo1 === 1'b1 && p1 !== 1'b1) rise1++;
        p1 = bo1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    initial begin
        int exp_a[6];
        int exp_b[10];

        Rst = 1'b1;
        bi0 = 1'b0;
        bi1 = 1'b0;

        // Reset held with bi toggling
        #2 Rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #7;
            bi0 = ~bi0;
            bi1 = ~bi1;
            #1;
            check("rst_hold_bo0", 32'(bo0), 0);
            check("rst_hold_bo1", 32'(bo1), 0);
        end
        bi0 = 1'b0;
        bi1 = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("post_rst_idle", 32'({bo1, bo0}), 0);
        end

        // Single press held 4 periods: pulse two edges after the first sampling edge
        exp_a = '{0, 0, 1, 0, 0, 0};
        @(negedge Clk);
        bi0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check($sformatf("single_press[%0d]", i), 32'(bo0), 32'(exp_a[i]));
            if (i == 3) bi0 = 1'b0;
        end
        idle(4);

        // Long hold, then re-press
        r_snap = rise0;
        h_snap = hi0;
        bi0 = 1'b1;
        idle(100);
        bi0 = 1'b0;
        idle(5);
        check("long_hold_pulses", 32'(rise0 - r_snap), 1);
        check("long_hold_width", 32'(hi0 - h_snap), 1);
        r_snap = rise0;
        h_snap = hi0;
        bi0 = 1'b1;
        idle(5);
        bi0 = 1'b0;
        idle(5);
        check("repress_pulses", 32'(rise0 - r_snap), 1);
        check("repress_width", 32'(hi0 - h_snap), 1);

        // One-cycle press still yields one pulse
        r_snap = rise0;
        h_snap = hi0;
        bi0 = 1'b1;
        idle(1);
        bi0 = 1'b0;
        idle(6);
        check("one_cycle_press", 32'(rise0 - r_snap), 1);
        check("one_cycle_width", 32'(hi0 - h_snap), 1);

        // Back-to-back single-clock low gaps: one pulse per re-press
        r_snap = rise0;
        h_snap = hi0;
        for (int k = 0; k < 3; k++) begin
            bi0 = 1'b1;
            idle(3);
            bi0 = 1'b0;
            idle(1);
        end
        idle(5);
        check("gap_pulses", 32'(rise0 - r_snap), 3);
        check("gap_width", 32'(hi0 - h_snap), 3);

        // Debounce: 3-cycle glitch rejected
        r_snap = rise1;
        bi1 = 1'b1;
        idle(3);
        bi1 = 1'b0;
        idle(12);
        check("deb_glitch", 32'(rise1 - r_snap), 0);

        // Debounce: 6-cycle press, pulse at latency SYNC_STAGES+4
        exp_b = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        r_snap = rise1;
        h_snap = hi1;
        bi1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check($sformatf("deb_press[%0d]", i), 32'(bo1), 32'(exp_b[i]));
            if (i == 5) bi1 = 1'b0;
        end
        idle(12);
        check("deb_press_pulses", 32'(rise1 - r_snap), 1);
        check("deb_press_width", 32'(hi1 - h_snap), 1);

        // Reset asserted in the pulse cycle truncates bo at once
        bi0 = 1'b1;
        idle(2);
        @(negedge Clk);
        check("pre_rst_pulse", 32'(bo0), 1);
        #5 Rst = 1'b0;
        #1 check("rst_truncate", 32'(bo0), 0);
        @(negedge Clk);
        check("rst_held_low", 32'(bo0), 0);
        r_snap = rise0;
        h_snap = hi0;
        Rst = 1'b1;
        exp_a = '{0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check($sformatf("post_rst_press[%0d]", i), 32'(bo0), 32'(exp_a[i]));
        end
        check("post_rst_pulses", 32'(rise0 - r_snap), 1);
        bi0 = 1'b0;
        idle(5);

        // Ten presses separated by idle gaps
        r_snap = rise0;
        h_snap = hi0;
        for (int k = 0; k < 10; k++) begin
            bi0 = 1'b1;
            idle(2);
            bi0 = 1'b0;
            idle(4);
        end
        idle(5);
        check("ten_press_pulses", 32'(rise0 - r_snap), 10);
        check("ten_press_width", 32'(hi0 - h_snap), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
